sti_load_scheduler: RTL and testbench
=====================================

Name: sti_load_scheduler

Overview:
- Sequences the STI serializer/DAC datapath by sharing its single parallel-load port between two word requesters.
- Arbitrates between the requesters round-robin and latches the winner's word and format fields.
- Issues a one-cycle load, then tracks the serializer's so_valid burst to know when the next word may be issued.
- Checks the burst length against the requested length, and stops issuing after a word flagged as last; done is then set once pixel_finish is seen.

Parameters:
- START_TIMEOUT, 8, max cycles waited in WAIT_START for so_valid to rise before flagging err
- CNT_W, 8, width of word_cnt

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  2  per-requester request; held high until matching gnt bit pulses
- r0_data  input  16  requester 0 word
- r0_cfg  input  6  requester 0 {last, length[1:0], fill, msb, low}
- r1_data  input  16  requester 1 word
- r1_cfg  input  6  requester 1 {last, length[1:0], fill, msb, low}
- gnt  output  2  one-hot one-cycle pulse; the word was captured this cycle
- load  output  1  one-cycle load strobe to serializer
- pi_data  output  16  latched word
- pi_length  output  2  latched length code (0=8, 1=16, 2=24, 3=32 bits)
- pi_fill  output  1  latched fill
- pi_msb  output  1  latched msb
- pi_low  output  1  latched low
- pi_end  output  1  latched last; held until reset once set
- so_valid  input  1  serializer serial-output valid
- pixel_finish  input  1  DAC finished frame
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  sticky; set when pixel_finish is seen in DONE
- err  output  1  sticky; set on burst-length mismatch or start timeout
- word_cnt  output  CNT_W  words issued; wraps modulo 2^CNT_W

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer prefers requester 0.
- IDLE: if any req bit is high, grant one requester.
  - Both requesting: grant the one not granted last.
  - The winner's data/cfg go into the pi_* registers and its gnt bit pulses this same cycle.
  - Next state LOAD.
  - No req: stay in IDLE with gnt=0.
- LOAD: load=1 for exactly one cycle; word_cnt increments; next state WAIT_START.
- pi_* fields stay stable from the capture cycle until the next capture.
- WAIT_START:
  - A timer counts cycles here.
  - so_valid=1: go to SHIFT; the bit counter loads 1.
  - Timer reaches START_TIMEOUT: set err; go to IDLE if latched last=0, else DONE.
- SHIFT:
  - Each cycle with so_valid=1, the 6-bit bit counter increments.
  - First cycle with so_valid=0: compare the count with 8*(length+1).
  - Mismatch: set err.
  - Then go to DONE if latched last=1, else IDLE.
- DONE: gnt stays 0 and req is ignored; pi_end stays 1; done is set on the first pixel_finish=1 and holds until reset.
- Minimum spacing between load pulses: load → WAIT_START → SHIFT(n bits) → IDLE → LOAD.
- Simultaneous events:
  - A req that rises in the cycle the FSM enters IDLE is honoured on that IDLE cycle.
  - so_valid already high in LOAD is ignored; only WAIT_START observes the rising edge.
- A reset during any state aborts immediately: load=0, gnt=0, all flags cleared. The serializer is reset by the same signal.
- Requester protocol: cfg/data must be valid whenever its req bit is high. Dropping req before gnt withdraws the request with no side effect.

Test Plan:
- Single word: req=01, r0_data=16'hA55A, cfg={0,2'b01,0,1,0} → gnt=01 in one cycle, load pulse with pi_data=A55A and pi_length=1 the next cycle, 16 so_valid cycles accepted, err=0, word_cnt=1, back to IDLE.
- Fairness: req=11 held for 4 words → gnt sequence 01, 10, 01, 10; each pi_data matches the granted source.
- Last word: r1_cfg last=1, length=3, 32-bit burst → FSM in DONE and pi_end=1; a new req=01 gets no gnt; pixel_finish pulse → done=1 and stays 1.
- Length mismatch: length=0 requested, bench drives only 7 so_valid cycles → err=1 at burst end; FSM returns to IDLE and keeps serving.
- Timeout: after load, so_valid held 0 → err=1 exactly START_TIMEOUT=8 cycles into WAIT_START; with last=0 the next req is granted.
- Reset mid-SHIFT: reset asserted during the 10th bit → next edge shows load=0, gnt=0, busy=0, err=0, word_cnt=0, pi_end=0; the next req is granted to requester 0.

Source files
------------

// File: rtl/sti_load_scheduler.sv
// Shares the STI serializer's single parallel-load port between two word requesters.
// Round-robin grant, one-cycle load, then tracks the so_valid burst and checks its length.
module sti_load_scheduler #(
  parameter int START_TIMEOUT = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [15:0]      r0_data,
  input  logic [5:0]       r0_cfg,
  input  logic [15:0]      r1_data,
  input  logic [5:0]       r1_cfg,
  output logic [1:0]       gnt,
  output logic             load,
  output logic [15:0]      pi_data,
  output logic [1:0]       pi_length,
  output logic             pi_fill,
  output logic             pi_msb,
  output logic             pi_low,
  output logic             pi_end,
  input  logic             so_valid,
  input  logic             pixel_finish,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int TMR_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_START, S_SHIFT, S_DONE
  } state_t;

  state_t           state_q;
  logic             rr_q;          // 1 = requester 1 wins a tie
  logic [TMR_W-1:0] timer_q;
  logic [5:0]       bit_cnt_q;
  logic             load_q;
  logic [15:0]      pi_data_q;
  logic [1:0]       pi_length_q;
  logic             pi_fill_q, pi_msb_q, pi_low_q, pi_end_q;
  logic             done_q, err_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic [1:0]       gnt_d;
  logic [5:0]       exp_bits;
  logic [5:0]       sel_cfg;
  logic [15:0]      sel_data;

  // The grant is combinational so the capture edge and the gnt pulse share a cycle.
  always_comb begin
    gnt_d = 2'b00;
    if (state_q == S_IDLE) begin
      if (req == 2'b11) gnt_d = rr_q ? 2'b10 : 2'b01;
      else              gnt_d = req;
    end
  end

  assign sel_cfg  = gnt_d[1] ? r1_cfg  : r0_cfg;
  assign sel_data = gnt_d[1] ? r1_data : r0_data;
  assign exp_bits = {1'b0, pi_length_q, 3'b000} + 6'd8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      load_q      <= 1'b0;
      pi_data_q   <= '0;
      pi_length_q <= '0;
      pi_fill_q   <= 1'b0;
      pi_msb_q    <= 1'b0;
      pi_low_q    <= 1'b0;
      pi_end_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|gnt_d) begin
            pi_data_q   <= sel_data;
            pi_end_q    <= pi_end_q | sel_cfg[5];
            pi_length_q <= sel_cfg[4:3];
            pi_fill_q   <= sel_cfg[2];
            pi_msb_q    <= sel_cfg[1];
            pi_low_q    <= sel_cfg[0];
            rr_q        <= gnt_d[0];
            load_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
          timer_q    <= '0;
          state_q    <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (so_valid) begin
            bit_cnt_q <= 6'd1;
            state_q   <= S_SHIFT;
          end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= pi_end_q ? S_DONE : S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_SHIFT: begin
          if (so_valid) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end else begin
            if (bit_cnt_q != exp_bits) err_q <= 1'b1;
            state_q <= pi_end_q ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (pixel_finish) done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_d;
  assign load      = load_q;
  assign pi_data   = pi_data_q;
  assign pi_length = pi_length_q;
  assign pi_fill   = pi_fill_q;
  assign pi_msb    = pi_msb_q;
  assign pi_low    = pi_low_q;
  assign pi_end    = pi_end_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_sti_load_scheduler.sv
// Randomized bench for sti_load_scheduler against a word-level reference model
// (round-robin preference, expected captured word, sticky error, issued-word count).
module tb_sti_load_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] r0_data, r1_data;
  logic [5:0]  r0_cfg, r1_cfg;
  logic [1:0]  gnt;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic        so_valid, pixel_finish;
  logic        busy, done, err;
  logic [7:0]  word_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_pref;
  int m_cnt;
  bit m_err;

  always #5 clk = ~clk;

  sti_load_scheduler #(.START_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .r0_data(r0_data), .r0_cfg(r0_cfg), .r1_data(r1_data), .r1_cfg(r1_cfg),
    .gnt(gnt), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .pixel_finish(pixel_finish),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] pick(input logic [1:0] r);
    if (r == 2'b11) return m_pref ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req = '0; so_valid = 1'b0; pixel_finish = 1'b0;
    r0_data = '0; r1_data = '0; r0_cfg = '0; r1_cfg = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_pref = 1'b0; m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
  endtask

  // Presents a request and waits (bounded) for the grant; returns in the LOAD cycle.
  task automatic drive_word(input logic [1:0] r, input logic [15:0] d0, input logic [5:0] c0,
                            input logic [15:0] d1, input logic [5:0] c1,
                            output logic [1:0] g, output bit tmo);
    req = r; r0_data = d0; r0_cfg = c0; r1_data = d1; r1_cfg = c1;
    g = 2'b00; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt !== 2'b00) begin g = gnt; tmo = 1'b0; break; end
      @(negedge clk);
    end
    if (!tmo) @(negedge clk);
    req = 2'b00;
  endtask

  // Called in the first WAIT_START cycle; drives n valid bits then one idle cycle.
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      so_valid = 1'b1;
      @(negedge clk);
    end
    so_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({load, gnt, busy, done, err, pi_end} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: load=%b gnt=%b busy=%b done=%b err=%b pi_end=%b required all 0",
               load, gnt, busy, done, err, pi_end);
    end
    checks++;
    if (word_cnt !== 8'd0 || pi_data !== 16'd0 || pi_length !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs: word_cnt=%0d pi_data=%h pi_length=%0d required 0", word_cnt, pi_data, pi_length);
    end
  endtask

  task automatic test_single_word();
    logic [1:0] g; bit tmo;
    apply_reset();
    drive_word(2'b01, 16'hA55A, 6'b001010, 16'h0000, 6'b0, g, tmo);
    checks++;
    if (tmo || g !== 2'b01) begin
      failures++; $display("FAIL single_gnt: gnt=%b timeout=%0d required 01", g, tmo);
    end
    checks++;
    if (load !== 1'b1 || pi_data !== 16'hA55A || pi_length !== 2'd1 || {pi_fill, pi_msb, pi_low} !== 3'b010) begin
      failures++;
      $display("FAIL single_load: load=%b pi_data=%h len=%0d fml=%b required 1 A55A 1 010",
               load, pi_data, pi_length, {pi_fill, pi_msb, pi_low});
    end
    @(negedge clk);
    checks++;
    if (load !== 1'b0 || busy !== 1'b1 || word_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_wait: load=%b busy=%b word_cnt=%0d required 0 1 1", load, busy, word_cnt);
    end
    burst(16);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || word_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_end: err=%b busy=%b word_cnt=%0d required 0 0 1", err, busy, word_cnt);
    end
  endtask

  // Random requests, fields and (optionally wrong) burst lengths against the model.
  task automatic test_words(input string name, input int n, input bit both_only, input bit allow_bad);
    logic [1:0] g, r, w; bit tmo, bad;
    logic [15:0] d0, d1, ed; logic [5:0] c0, c1, ec; int nb;
    for (int k = 0; k < n; k++) begin
      r  = both_only ? 2'b11 : 2'($urandom_range(1, 3));
      d0 = 16'($urandom); d1 = 16'($urandom);
      c0 = {1'b0, 5'($urandom)}; c1 = {1'b0, 5'($urandom)};
      w  = pick(r);
      ed = (w == 2'b01) ? d0 : d1;
      ec = (w == 2'b01) ? c0 : c1;
      drive_word(r, d0, c0, d1, c1, g, tmo);
      m_pref = (w == 2'b01);
      m_cnt++;
      checks++;
      if (tmo || g !== w) begin
        failures++; $display("FAIL %s_gnt[%0d]: gnt=%b required %b", name, k, g, w);
      end
      checks++;
      if (load !== 1'b1 || pi_data !== ed || {pi_end, pi_length, pi_fill, pi_msb, pi_low} !== ec) begin
        failures++;
        $display("FAIL %s_capture[%0d]: load=%b pi_data=%h cfg=%b required 1 %h %b", name, k, load, pi_data,
                 {pi_end, pi_length, pi_fill, pi_msb, pi_low}, ed, ec);
      end
      @(negedge clk);
      bad = allow_bad && ($urandom_range(0, 3) == 0);
      nb  = 8 * (int'(ec[4:3]) + 1) - (bad ? 1 : 0);
      m_err = m_err | bad;
      burst(nb);
      checks++;
      if (err !== m_err || word_cnt !== 8'(m_cnt) || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_end[%0d]: err=%b word_cnt=%0d busy=%b required %b %0d 0", name, k, err, word_cnt, busy,
                 m_err, m_cnt);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    test_words("fair", 4, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    apply_reset();
    test_words("rand", 12, 1'b0, 1'b1);
  endtask

  task automatic test_length_mismatch();
    logic [1:0] g; bit tmo;
    apply_reset();
    drive_word(2'b01, 16'h1234, 6'b000000, 16'h0, 6'b0, g, tmo);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL mismatch_pre: err=%b required 0", err); end
    burst(7);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mismatch_err: err=%b busy=%b required 1 0", err, busy);
    end
    drive_word(2'b10, 16'h0, 6'b0, 16'hBEEF, 6'b001000, g, tmo);
    checks++;
    if (tmo || g !== 2'b10 || pi_data !== 16'hBEEF) begin
      failures++; $display("FAIL mismatch_next: gnt=%b pi_data=%h required 10 BEEF", g, pi_data);
    end
    @(negedge clk);
    burst(16);
    checks++;
    if (err !== 1'b1 || word_cnt !== 8'd2) begin
      failures++; $display("FAIL mismatch_sticky: err=%b word_cnt=%0d required 1 2", err, word_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] g; bit tmo;
    apply_reset();
    drive_word(2'b01, 16'h0F0F, 6'b001000, 16'h0, 6'b0, g, tmo);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early: err=%b busy=%b required 0 1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_flag: err=%b busy=%b required 1 0", err, busy);
    end
    drive_word(2'b11, 16'h1111, 6'b0, 16'h2222, 6'b0, g, tmo);
    checks++;
    if (tmo || g !== 2'b10 || pi_data !== 16'h2222) begin
      failures++; $display("FAIL timeout_next: gnt=%b pi_data=%h required 10 2222", g, pi_data);
    end
    @(negedge clk);
    burst(8);
  endtask

  task automatic test_last_word();
    logic [1:0] g; bit tmo; int bad_gnt;
    apply_reset();
    drive_word(2'b10, 16'h0, 6'b0, 16'hC0DE, 6'b111000, g, tmo);
    checks++;
    if (tmo || g !== 2'b10 || pi_end !== 1'b1 || pi_length !== 2'd3) begin
      failures++; $display("FAIL last_gnt: gnt=%b pi_end=%b len=%0d required 10 1 3", g, pi_end, pi_length);
    end
    @(negedge clk);
    burst(32);
    checks++;
    if (busy !== 1'b0 || pi_end !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL last_done_state: busy=%b pi_end=%b err=%b done=%b required 0 1 0 0", busy, pi_end, err, done);
    end
    req = 2'b01; r0_data = 16'h5555; r0_cfg = 6'b0;
    bad_gnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (gnt !== 2'b00 || load !== 1'b0) bad_gnt++;
      @(negedge clk);
    end
    req = 2'b00;
    checks++;
    if (bad_gnt != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL last_ignore_req: grant_cycles=%0d busy=%b required 0 0", bad_gnt, busy);
    end
    pixel_finish = 1'b1;
    @(negedge clk);
    pixel_finish = 1'b0;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL last_done_set: done=%b required 1", done); end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pi_end !== 1'b1) begin
      failures++; $display("FAIL last_done_hold: done=%b pi_end=%b required 1 1", done, pi_end);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [1:0] g; bit tmo;
    apply_reset();
    drive_word(2'b01, 16'h7777, 6'b111000, 16'h0, 6'b0, g, tmo);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin so_valid = 1'b1; @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({load, gnt, busy, err, pi_end} !== 6'b0 || word_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_shift: load=%b gnt=%b busy=%b err=%b pi_end=%b word_cnt=%0d required all 0",
               load, gnt, busy, err, pi_end, word_cnt);
    end
    @(negedge clk);
    reset = 1'b0; so_valid = 1'b0;
    m_pref = 1'b0;
    @(negedge clk);
    drive_word(2'b11, 16'hAAAA, 6'b0, 16'hBBBB, 6'b0, g, tmo);
    checks++;
    if (tmo || g !== pick(2'b11) || pi_data !== 16'hAAAA) begin
      failures++; $display("FAIL reset_rr: gnt=%b pi_data=%h required 01 AAAA", g, pi_data);
    end
    @(negedge clk);
    burst(8);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fairness();
    test_random();
    test_length_mismatch();
    test_timeout();
    test_last_word();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
